video_timing: RTL and testbench

VIDEO_TIMING -- requirements
Module: video_timing

---
 rtl/video_pkg.sv | 29 ++
 rtl/video_axis_counter.sv | 51 +++++
 rtl/video_timing.sv | 147 ++++++++++++++
 tb/tb_video_timing.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the video timing generator: FSM states,
// coordinate width, default 640x480@60 timing and the colour-bar palette.
package video_pkg;

  localparam int COORD_W   = 11;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOPPING
  } state_e;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black is the
  // index with R on inverted bit 1, G on inverted bit 2 and B on inverted bit 0.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One timing axis: position counter with wrap, plus active-window and sync-window
// flags evaluated on the next position so the caller can register them in step.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic               hdmi_clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output logic [COORD_W-1:0] count_next,
  output logic               wrap,
  output logic               active_next,
  output logic               sync_next
);

  localparam logic [COORD_W-1:0] LAST_C       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACTIVE_C     = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_START_C = COORD_W'(SYNC_START);
  localparam logic [COORD_W-1:0] SYNC_END_C   = COORD_W'(SYNC_END);

  assign wrap = (count == LAST_C);

  // NOTE: default assignment first so no path leaves count_next unassigned (no latch).
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (advance) begin
      count_next = wrap ? '0 : count + COORD_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign active_next = (count_next < ACTIVE_C);
  assign sync_next   = (count_next >= SYNC_START_C) && (count_next < SYNC_END_C);

endmodule

// File: rtl/video_timing.sv
// Video timing generator with IDLE/RUN/STOPPING control; all outputs registered
// together. Define VIDEO_TIMING_PATTERN_EN to build the 8-bar colour test pattern.
module video_timing
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               hdmi_clk,
  input  logic               reset,
  input  logic               enable,
  output logic [2:0]         hve_sync,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_start,
  output logic               line_start,
  output logic               running,
  output logic [23:0]        rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_check
      $error("video_timing: H_TOTAL or V_TOTAL exceeds the 11-bit coordinate range");
    end
  endgenerate

  state_e state, state_next;

  logic               h_wrap, v_wrap, frame_end;
  logic               h_adv, v_adv, cnt_clear, run_next;
  logic               h_act, v_act, h_sync, v_sync;
  logic [COORD_W-1:0] x_next, y_next;

  assign frame_end = h_wrap & v_wrap;

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stopping only completes on the last pixel of a frame, so frames are never cut short.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (enable) state_next = ST_RUN;
      ST_RUN:      if (!enable) state_next = ST_STOPPING;
      ST_STOPPING: begin
        if (enable)         state_next = ST_RUN;
        else if (frame_end) state_next = ST_IDLE;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    running   = (state != ST_IDLE);
    run_next  = (state_next != ST_IDLE);
    h_adv     = running;
    v_adv     = running & h_wrap;
    cnt_clear = ~run_next;
  end

  video_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .hdmi_clk    (hdmi_clk),
    .reset       (reset),
    .clear       (cnt_clear),
    .advance     (h_adv),
    .count       (x),
    .count_next  (x_next),
    .wrap        (h_wrap),
    .active_next (h_act),
    .sync_next   (h_sync)
  );

  video_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .hdmi_clk    (hdmi_clk),
    .reset       (reset),
    .clear       (cnt_clear),
    .advance     (v_adv),
    .count       (y),
    .count_next  (y_next),
    .wrap        (v_wrap),
    .active_next (v_act),
    .sync_next   (v_sync)
  );

  // Flags are computed from the next coordinates so they land on the same edge as x/y.
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      hve_sync    <= {1'b0, ~SYNC_POL, ~SYNC_POL};
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hve_sync    <= {run_next & h_act & v_act,
                      (run_next & v_sync) ? SYNC_POL : ~SYNC_POL,
                      (run_next & h_sync) ? SYNC_POL : ~SYNC_POL};
      frame_start <= run_next && (x_next == '0) && (y_next == '0);
      line_start  <= run_next && (x_next == '0);
    end
  end

`ifdef VIDEO_TIMING_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [COORD_W-1:0] bar_idx_wide;
  logic [2:0]         bar_idx;

  always_comb begin
    bar_idx_wide = x_next / COORD_W'(BAR_W);
    bar_idx      = (bar_idx_wide > COORD_W'(7)) ? 3'd7 : bar_idx_wide[2:0];
  end

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      rgb <= '0;
    end else begin
      rgb <= (run_next & h_act & v_act) ? bar_colour(bar_idx) : '0;
    end
  end
`else
  assign rgb = '0;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: default 800x525 timing, a tiny 7x5 positive-sync
// instance and a 12x525 instance for full-frame vertical checks.
module tb_video_timing;

  logic clk = 1'b0;
  logic rst;
  logic en_a, en_b, en_c;

  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;
  int a_pos, b_pos, c_pos;

  logic [2:0]  hve_a, hve_b, hve_c;
  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic        fs_a, ls_a, run_a, fs_b, ls_b, run_b, fs_c, ls_c, run_c;
  logic [23:0] rgb_a, rgb_b, rgb_c;
  logic [51:0] obs_a, obs_b, obs_c;

  assign obs_a = {run_a, fs_a, ls_a, hve_a, x_a, y_a, rgb_a};
  assign obs_b = {run_b, fs_b, ls_b, hve_b, x_b, y_b, rgb_b};
  assign obs_c = {run_c, fs_c, ls_c, hve_c, x_c, y_c, rgb_c};

  video_timing dut_a (
    .hdmi_clk(clk), .reset(rst), .enable(en_a), .hve_sync(hve_a), .x(x_a), .y(y_a),
    .frame_start(fs_a), .line_start(ls_a), .running(run_a), .rgb(rgb_a)
  );

  video_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_b (
    .hdmi_clk(clk), .reset(rst), .enable(en_b), .hve_sync(hve_b), .x(x_b), .y(y_b),
    .frame_start(fs_b), .line_start(ls_b), .running(run_b), .rgb(rgb_b)
  );

  video_timing #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) dut_c (
    .hdmi_clk(clk), .reset(rst), .enable(en_c), .hve_sync(hve_c), .x(x_c), .y(y_c),
    .frame_start(fs_c), .line_start(ls_c), .running(run_c), .rgb(rgb_c)
  );

  function automatic logic [23:0] exp_bar(input int ex, input int ha);
    int w;
    int idx;
    w   = (ha / 8 > 0) ? ha / 8 : 1;
    idx = ex / w;
    if (idx > 7) idx = 7;
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected {running, frame_start, line_start, de, vsync, hsync, x, y, rgb}.
  function automatic logic [51:0] model(input bit run, input int ex, input int ey,
                                        input int ha, input int hf, input int hs,
                                        input int va, input int vf, input int vs,
                                        input bit pol);
    logic        de, hsync, vsync;
    logic [23:0] c;
    if (!run) return {3'b000, 1'b0, ~pol, ~pol, 11'd0, 11'd0, 24'd0};
    de    = (ex < ha) && (ey < va);
    hsync = (ex >= ha + hf && ex < ha + hf + hs) ? pol : ~pol;
    vsync = (ey >= va + vf && ey < va + vf + vs) ? pol : ~pol;
    c     = 24'd0;
`ifdef VIDEO_TIMING_PATTERN_EN
    if (de) c = exp_bar(ex, ha);
`endif
    return {1'b1, (ex == 0 && ey == 0), (ex == 0), de, vsync, hsync,
            11'(ex), 11'(ey), c};
  endfunction

  function automatic logic [51:0] model_a(input int p);
    return model(1'b1, p % 800, (p / 800) % 525, 640, 16, 96, 480, 10, 2, 1'b0);
  endfunction

  function automatic logic [51:0] model_b(input int p);
    return model(1'b1, p % 7, (p / 7) % 5, 4, 1, 1, 2, 1, 1, 1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [51:0] idle0, idle1;
    idle0 = model(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    idle1 = model(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    step(); step();
    vecs++;
    if (obs_a !== idle0) begin
      miscompares++;
      $display("FAIL reset_a: got %h expected %h", obs_a, idle0);
    end
    vecs++;
    if (obs_b !== idle1) begin
      miscompares++;
      $display("FAIL reset_b: got %h expected %h", obs_b, idle1);
    end
    vecs++;
    if (obs_c !== idle0) begin
      miscompares++;
      $display("FAIL reset_c: got %h expected %h", obs_c, idle0);
    end
    rst = 1'b0;
    step(); step(); step();
    vecs++;
    if (obs_a !== idle0) begin
      miscompares++;
      $display("FAIL idle_hold_a: got %h expected %h", obs_a, idle0);
    end
  endtask

  task automatic test_start_and_lines();
    en_a = 1'b1;
    for (int n = 0; n < 2400; n++) begin
      step();
      a_pos = n;
      vecs++;
      if (obs_a !== model_a(a_pos)) begin
        miscompares++;
        $display("FAIL lines_a pos=%0d: got %h expected %h", a_pos, obs_a, model_a(a_pos));
      end
    end
  endtask

  task automatic test_toggle();
    for (int k = 0; k < 40; k++) begin
      if (k == 5)  en_a = 1'b0;
      if (k == 12) en_a = 1'b1;
      step();
      a_pos++;
      vecs++;
      if (obs_a !== model_a(a_pos)) begin
        miscompares++;
        $display("FAIL toggle_a pos=%0d: got %h expected %h", a_pos, obs_a, model_a(a_pos));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [51:0] idle0;
    idle0 = model(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    while (a_pos < 3 * 800 + 300) begin
      step();
      a_pos++;
    end
    vecs++;
    if (x_a !== 11'd300 || y_a !== 11'd3) begin
      miscompares++;
      $display("FAIL pre_reset_pos: got x=%0d y=%0d expected x=300 y=3", x_a, y_a);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (obs_a !== idle0) begin
      miscompares++;
      $display("FAIL async_reset_a: got %h expected %h", obs_a, idle0);
    end
    step(); step();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      vecs++;
      if (obs_a !== model_a(n)) begin
        miscompares++;
        $display("FAIL restart_a pos=%0d: got %h expected %h", n, obs_a, model_a(n));
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_small_frames();
    en_b = 1'b1;
    for (int n = 0; n < 70; n++) begin
      step();
      b_pos = n;
      vecs++;
      if (obs_b !== model_b(b_pos)) begin
        miscompares++;
        $display("FAIL small_b pos=%0d: got %h expected %h", b_pos, obs_b, model_b(b_pos));
      end
    end
  endtask

  task automatic test_stop();
    logic [51:0] idle1;
    idle1 = model(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    while (b_pos < 104) begin
      step();
      b_pos++;
      vecs++;
      if (obs_b !== model_b(b_pos)) begin
        miscompares++;
        $display("FAIL stop_b pos=%0d: got %h expected %h", b_pos, obs_b, model_b(b_pos));
      end
      if (b_pos == 79) en_b = 1'b0;
    end
    for (int n = 0; n < 4; n++) begin
      step();
      vecs++;
      if (obs_b !== idle1) begin
        miscompares++;
        $display("FAIL stopped_idle_b cyc=%0d: got %h expected %h", n, obs_b, idle1);
      end
    end
  endtask

  task automatic test_vertical();
    int de_cnt, vs_cnt, fs_cnt;
    logic [51:0] e;
    de_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    en_c = 1'b1;
    for (int n = 0; n <= 6300; n++) begin
      step();
      c_pos = n;
      e = model(1'b1, c_pos % 12, (c_pos / 12) % 525, 8, 1, 2, 480, 10, 2, 1'b0);
      vecs++;
      if (obs_c !== e) begin
        miscompares++;
        $display("FAIL vert_c pos=%0d: got %h expected %h", c_pos, obs_c, e);
      end
      if (n < 6300) begin
        if (hve_c[2]) de_cnt++;
        if (!hve_c[1]) vs_cnt++;
        if (fs_c) fs_cnt++;
      end
    end
    en_c = 1'b0;
    vecs++;
    if (de_cnt !== 3840) begin
      miscompares++;
      $display("FAIL de_count_c: got %0d expected 3840", de_cnt);
    end
    vecs++;
    if (vs_cnt !== 24) begin
      miscompares++;
      $display("FAIL vsync_count_c: got %0d expected 24", vs_cnt);
    end
    vecs++;
    if (fs_cnt !== 1) begin
      miscompares++;
      $display("FAIL frame_start_count_c: got %0d expected 1", fs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_start_and_lines();
    test_toggle();
    test_reset_midframe();
    test_small_frames();
    test_stop();
    test_vertical();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
